// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data memory.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if;
   logic        p0_req;
   logic        p0_we;
   logic [2:0]  p0_funct3;
   logic [31:0] p0_addr;
   logic [31:0] p0_wdata;
   logic        p0_gnt;
   logic        p0_rvalid;
   logic [31:0] p0_rdata;
   logic        p0_err;

   logic        p1_req;
   logic        p1_we;
   logic [2:0]  p1_funct3;
   logic [31:0] p1_addr;
   logic [31:0] p1_wdata;
   logic        p1_gnt;
   logic        p1_rvalid;
   logic [31:0] p1_rdata;
   logic        p1_err;

   logic [6:0]  m_ctrl;
   logic [2:0]  m_funct3;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   modport slave (
      input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
      output p0_gnt, p0_rvalid, p0_rdata, p0_err,
      input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata, p1_err,
      output m_ctrl, m_funct3, m_addr, m_wdata,
      input  m_rdata
   );

   modport master (
      output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
      output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
      input  m_ctrl, m_funct3, m_addr, m_wdata,
      output m_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// DMEM_ARB_PERF_EN adds saturating grant/conflict counters.
module dmem_arbiter #(
   parameter int MEM_BYTES = 64,
   parameter int DATA_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_gnt0,
   output logic [31:0] perf_gnt1,
   output logic [31:0] perf_conflict
`endif
);

   localparam logic [6:0] CTRL_ST   = 7'b0100011;
   localparam logic [6:0] CTRL_LD   = 7'b0000011;
   localparam logic [6:0] CTRL_IDLE = 7'b0010011;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state;
   state_t state_nxt;

   logic              last_gnt;
   logic              gnt0;
   logic              gnt1;
   logic              xfer;
   logic [6:0]        ctrl;

   logic              sel_we;
   logic [2:0]        sel_funct3;
   logic [31:0]       sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic [2:0]        size;
   logic [32:0]       end_addr;
   logic              f3_ok;
   logic              legal;

   logic              l_we;
   logic [2:0]        l_funct3;
   logic [31:0]       l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_port;
   logic              l_err;

   assign xfer = gnt0 | gnt1;

   assign sel_we     = gnt1 ? bus.p1_we     : bus.p0_we;
   assign sel_funct3 = gnt1 ? bus.p1_funct3 : bus.p0_funct3;
   assign sel_addr   = gnt1 ? bus.p1_addr   : bus.p0_addr;
   assign sel_wdata  = gnt1 ? bus.p1_wdata  : bus.p0_wdata;

   // Legality of the access being granted: funct3 and 33-bit range check
   always_comb begin
      size  = 3'd0;
      f3_ok = 1'b0;
      case (sel_funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         2'b10:   size = 3'd4;
         default: size = 3'd0;
      endcase
      if (sel_we)
         f3_ok = (sel_funct3 == 3'b000) || (sel_funct3 == 3'b001) ||
                 (sel_funct3 == 3'b010);
      else
         f3_ok = (sel_funct3 == 3'b000) || (sel_funct3 == 3'b001) ||
                 (sel_funct3 == 3'b010) || (sel_funct3 == 3'b100) ||
                 (sel_funct3 == 3'b101);
   end

   assign end_addr = {1'b0, sel_addr} + {30'd0, size};
   assign legal    = f3_ok && (end_addr <= 33'(MEM_BYTES));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, grants and memory command
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      ctrl      = CTRL_IDLE;
      case (state)
         IDLE: begin
            if (bus.p0_req && bus.p1_req) begin
               gnt0 = last_gnt;
               gnt1 = !last_gnt;
            end else begin
               gnt0 = bus.p0_req;
               gnt1 = bus.p1_req;
            end
            if (gnt0 || gnt1)
               state_nxt = legal ? ISSUE : RESP;
         end
         ISSUE: begin
            ctrl      = l_we ? CTRL_ST : CTRL_LD;
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the granted request and remember the winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= 1'b1;
         l_we     <= 1'b0;
         l_funct3 <= 3'd0;
         l_addr   <= 32'd0;
         l_wdata  <= '0;
         l_port   <= 1'b0;
         l_err    <= 1'b0;
      end else if (xfer) begin
         last_gnt <= gnt1;
         l_we     <= sel_we;
         l_funct3 <= sel_funct3;
         l_addr   <= sel_addr;
         l_wdata  <= sel_wdata;
         l_port   <= gnt1;
         l_err    <= !legal;
      end
   end

   // Register the per-port completion pulse leaving RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.p0_rvalid <= 1'b0;
         bus.p0_err    <= 1'b0;
         bus.p0_rdata  <= 32'd0;
         bus.p1_rvalid <= 1'b0;
         bus.p1_err    <= 1'b0;
         bus.p1_rdata  <= 32'd0;
      end else begin
         bus.p0_rvalid <= 1'b0;
         bus.p0_err    <= 1'b0;
         bus.p1_rvalid <= 1'b0;
         bus.p1_err    <= 1'b0;
         if (state == RESP) begin
            if (l_port) begin
               bus.p1_rvalid <= 1'b1;
               bus.p1_err    <= l_err;
               bus.p1_rdata  <= (!l_we && !l_err) ? bus.m_rdata : 32'd0;
            end else begin
               bus.p0_rvalid <= 1'b1;
               bus.p0_err    <= l_err;
               bus.p0_rdata  <= (!l_we && !l_err) ? bus.m_rdata : 32'd0;
            end
         end
      end
   end

   assign bus.p0_gnt   = gnt0;
   assign bus.p1_gnt   = gnt1;
   assign bus.m_ctrl   = ctrl;
   assign bus.m_funct3 = l_funct3;
   assign bus.m_addr   = l_addr;
   assign bus.m_wdata  = l_wdata;

`ifdef DMEM_ARB_PERF_EN
   // Saturating grant and conflict counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_gnt0     <= 32'd0;
         perf_gnt1     <= 32'd0;
         perf_conflict <= 32'd0;
      end else begin
         if (gnt0 && (perf_gnt0 != 32'hFFFF_FFFF))
            perf_gnt0 <= perf_gnt0 + 32'd1;
         if (gnt1 && (perf_gnt1 != 32'hFFFF_FFFF))
            perf_gnt1 <= perf_gnt1 + 32'd1;
         if ((state == IDLE) && bus.p0_req && bus.p1_req &&
             (perf_conflict != 32'hFFFF_FFFF))
            perf_conflict <= perf_conflict + 32'd1;
      end
   end
`else
   // No performance counters in this build
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// 64-byte memory; DMEM_ARB_PERF_EN also checks the counters.
module tb_dmem_arbiter;

   localparam logic [6:0] CTRL_ST   = 7'b0100011;
   localparam logic [6:0] CTRL_LD   = 7'b0000011;
   localparam logic [6:0] CTRL_IDLE = 7'b0010011;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   dmem_arbiter_if bus();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_gnt0;
   logic [31:0] perf_gnt1;
   logic [31:0] perf_conflict;
`endif

   dmem_arbiter #(.MEM_BYTES(64), .DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_gnt0(perf_gnt0),
      .perf_gnt1(perf_gnt1),
      .perf_conflict(perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: writes on store edge, registered extended read
   logic [7:0] mem [64];
   logic [5:0] ma;
   logic [31:0] word;
   assign ma = bus.m_addr[5:0];
   assign word = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};

   always @(posedge clk) begin
      if (bus.m_ctrl == CTRL_ST) begin
         mem[ma] <= bus.m_wdata[7:0];
         if (bus.m_funct3[1:0] != 2'b00)
            mem[ma + 6'd1] <= bus.m_wdata[15:8];
         if (bus.m_funct3[1:0] == 2'b10) begin
            mem[ma + 6'd2] <= bus.m_wdata[23:16];
            mem[ma + 6'd3] <= bus.m_wdata[31:24];
         end
      end
      if (bus.m_ctrl == CTRL_LD) begin
         case (bus.m_funct3)
            3'b000:  bus.m_rdata <= {{24{word[7]}}, word[7:0]};
            3'b001:  bus.m_rdata <= {{16{word[15]}}, word[15:0]};
            3'b100:  bus.m_rdata <= {24'd0, word[7:0]};
            3'b101:  bus.m_rdata <= {16'd0, word[15:0]};
            default: bus.m_rdata <= word;
         endcase
      end
   end

   task automatic clear_reqs();
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
   endtask

   task automatic pulse_reset();
      clear_reqs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Drive one request on a port; report latency from grant to rvalid
   task automatic xfer(
      input  bit          port,
      input  bit          we,
      input  logic [2:0]  f3,
      input  logic [31:0] addr,
      input  logic [31:0] wd,
      output int          lat,
      output logic [31:0] rd,
      output logic        er,
      output bit          saw_mem
   );
      bit g;
      bit rv;
      lat     = -1;
      rd      = 32'hxxxx_xxxx;
      er      = 1'bx;
      saw_mem = 1'b0;
      g       = 1'b0;
      if (port) begin
         bus.p1_we = we; bus.p1_funct3 = f3;
         bus.p1_addr = addr; bus.p1_wdata = wd;
         bus.p1_req = 1'b1;
      end else begin
         bus.p0_we = we; bus.p0_funct3 = f3;
         bus.p0_addr = addr; bus.p0_wdata = wd;
         bus.p0_req = 1'b1;
      end
      #1;
      for (int k = 0; k < 8; k++) begin
         g = port ? bus.p1_gnt : bus.p0_gnt;
         if (g) break;
         @(posedge clk);
         #1;
      end
      if (!g) begin
         clear_reqs();
         return;
      end
      @(posedge clk);
      #1;
      clear_reqs();
      for (int k = 1; k <= 8; k++) begin
         if (bus.m_ctrl != CTRL_IDLE) saw_mem = 1'b1;
         rv = port ? bus.p1_rvalid : bus.p0_rvalid;
         if (rv) begin
            lat = k;
            rd  = port ? bus.p1_rdata : bus.p0_rdata;
            er  = port ? bus.p1_err : bus.p0_err;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt: got %b%b want 00", bus.p0_gnt, bus.p1_gnt);
      end
      checks++;
      if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rvalid: got %b%b want 00",
                  bus.p0_rvalid, bus.p1_rvalid);
      end
      checks++;
      if (bus.p0_err !== 1'b0 || bus.p1_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b%b want 00", bus.p0_err, bus.p1_err);
      end
      checks++;
      if (bus.p0_rdata !== 32'd0 || bus.p1_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %h %h want 0",
                  bus.p0_rdata, bus.p1_rdata);
      end
      checks++;
      if (bus.m_ctrl !== CTRL_IDLE) begin
         errors++;
         $display("FAIL reset_mctrl: got %b want %b", bus.m_ctrl, CTRL_IDLE);
      end
      checks++;
      if (bus.m_addr !== 32'd0 || bus.m_wdata !== 32'd0 ||
          bus.m_funct3 !== 3'd0) begin
         errors++;
         $display("FAIL reset_latched: got %h %h %h want 0",
                  bus.m_addr, bus.m_wdata, bus.m_funct3);
      end
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] rd; logic er; bit sm;
      xfer(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, sm);
      checks++;
      if (lat !== 3 || er !== 1'b0) begin
         errors++;
         $display("FAIL sw_lat: got lat=%0d err=%b want lat=3 err=0", lat, er);
      end
      xfer(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL lw_lat: got %0d want 3", lat);
      end
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++;
         $display("FAIL lw_data: got %h err=%b want deadbeef err=0", rd, er);
      end
   endtask

   task automatic test_sign_ext();
      int lat; logic [31:0] rd; logic er; bit sm;
      xfer(1'b1, 1'b1, 3'b000, 32'h08, 32'h0000_0080, lat, rd, er, sm);
      checks++;
      if (lat !== 3 || er !== 1'b0) begin
         errors++;
         $display("FAIL sb_p1: got lat=%0d err=%b want lat=3 err=0", lat, er);
      end
      xfer(1'b1, 1'b0, 3'b000, 32'h08, 32'h0, lat, rd, er, sm);
      checks++;
      if (rd !== 32'hFFFF_FF80 || lat !== 3) begin
         errors++;
         $display("FAIL lb_p1: got %h lat=%0d want ffffff80 lat=3", rd, lat);
      end
      xfer(1'b1, 1'b0, 3'b100, 32'h08, 32'h0, lat, rd, er, sm);
      checks++;
      if (rd !== 32'h0000_0080 || lat !== 3) begin
         errors++;
         $display("FAIL lbu_p1: got %h lat=%0d want 00000080 lat=3", rd, lat);
      end
   endtask

   task automatic test_reject();
      int lat; logic [31:0] rd; logic er; bit sm;
      xfer(1'b0, 1'b0, 3'b010, 32'd62, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL lw62: got lat=%0d err=%b rd=%h want 2 1 0",
                  lat, er, rd);
      end
      checks++;
      if (sm !== 1'b0) begin
         errors++;
         $display("FAIL lw62_mem: got mem access=%b want 0", sm);
      end
      xfer(1'b0, 1'b1, 3'b100, 32'd0, 32'h5555_5555, lat, rd, er, sm);
      checks++;
      if (lat !== 2 || er !== 1'b1 || sm !== 1'b0) begin
         errors++;
         $display("FAIL sw_f3_100: got lat=%0d err=%b mem=%b want 2 1 0",
                  lat, er, sm);
      end
      xfer(1'b0, 1'b0, 3'b010, 32'd60, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 3 || er !== 1'b0) begin
         errors++;
         $display("FAIL lw60_edge: got lat=%0d err=%b want 3 0", lat, er);
      end
      xfer(1'b0, 1'b0, 3'b000, 32'd63, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 3 || er !== 1'b0) begin
         errors++;
         $display("FAIL lb63_edge: got lat=%0d err=%b want 3 0", lat, er);
      end
      xfer(1'b0, 1'b0, 3'b000, 32'd64, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 2 || er !== 1'b1) begin
         errors++;
         $display("FAIL lb64: got lat=%0d err=%b want 2 1", lat, er);
      end
      xfer(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 2 || er !== 1'b1) begin
         errors++;
         $display("FAIL lw_wrap: got lat=%0d err=%b want 2 1", lat, er);
      end
      xfer(1'b0, 1'b0, 3'b110, 32'd0, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 2 || er !== 1'b1) begin
         errors++;
         $display("FAIL ld_f3_110: got lat=%0d err=%b want 2 1", lat, er);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er; bit sm; int nrv;
      bus.p0_we = 1'b1; bus.p0_funct3 = 3'b010;
      bus.p0_addr = 32'h20; bus.p0_wdata = 32'h1234_5678;
      bus.p0_req = 1'b1;
      #1;
      checks++;
      if (bus.p0_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_gnt: got %b want 1", bus.p0_gnt);
      end
      @(posedge clk);
      #1;
      clear_reqs();
      checks++;
      if (bus.m_ctrl !== CTRL_ST) begin
         errors++;
         $display("FAIL mid_issue: got %b want %b", bus.m_ctrl, CTRL_ST);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.m_ctrl !== CTRL_IDLE || bus.m_addr !== 32'd0 ||
          bus.p0_rdata !== 32'd0 || bus.p0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst: got ctrl=%b addr=%h rd=%h rv=%b want idle 0 0 0",
                  bus.m_ctrl, bus.m_addr, bus.p0_rdata, bus.p0_rvalid);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      nrv = 0;
      for (int k = 0; k < 4; k++) begin
         if (bus.p0_rvalid || bus.p1_rvalid) nrv++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (nrv !== 0) begin
         errors++;
         $display("FAIL mid_no_rvalid: got %0d pulses want 0", nrv);
      end
      xfer(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, sm);
      checks++;
      if (lat !== 3 || rd !== 32'd0 || er !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: got lat=%0d rd=%h err=%b want 3 0 0",
                  lat, rd, er);
      end
   endtask

   task automatic test_round_robin();
      bit g0 [13];
      bit g1 [13];
      bit r0 [13];
      bit r1 [13];
      int bad;
      pulse_reset();
      bus.p0_we = 1'b0; bus.p0_funct3 = 3'b010; bus.p0_addr = 32'h10;
      bus.p1_we = 1'b0; bus.p1_funct3 = 3'b010; bus.p1_addr = 32'h10;
      bus.p0_req = 1'b1;
      bus.p1_req = 1'b1;
      #1;
      for (int c = 0; c < 13; c++) begin
         if (c == 10) clear_reqs();
         #1;
         g0[c] = bus.p0_gnt; g1[c] = bus.p1_gnt;
         r0[c] = bus.p0_rvalid; r1[c] = bus.p1_rvalid;
         @(posedge clk);
         #1;
      end
      checks++;
      if (g0[0] !== 1'b1 || g1[0] !== 1'b0) begin
         errors++;
         $display("FAIL rr_first: got g0=%b g1=%b want 1 0", g0[0], g1[0]);
      end
      checks++;
      if (g1[3] !== 1'b1 || g0[3] !== 1'b0) begin
         errors++;
         $display("FAIL rr_second: got g0=%b g1=%b want 0 1", g0[3], g1[3]);
      end
      checks++;
      if (g0[6] !== 1'b1 || g1[6] !== 1'b0) begin
         errors++;
         $display("FAIL rr_third: got g0=%b g1=%b want 1 0", g0[6], g1[6]);
      end
      checks++;
      if (g1[9] !== 1'b1 || g0[9] !== 1'b0) begin
         errors++;
         $display("FAIL rr_fourth: got g0=%b g1=%b want 0 1", g0[9], g1[9]);
      end
      bad = 0;
      for (int c = 0; c < 13; c++) begin
         if ((c % 3) != 0 && (g0[c] || g1[c])) bad++;
         if (r0[c] !== (c == 3 || c == 9)) bad++;
         if (r1[c] !== (c == 6 || c == 12)) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL rr_timing: got %0d bad cycles want 0", bad);
      end
`ifdef DMEM_ARB_PERF_EN
      checks++;
      if (perf_gnt0 !== 32'd2 || perf_gnt1 !== 32'd2) begin
         errors++;
         $display("FAIL perf_gnt: got %0d %0d want 2 2", perf_gnt0, perf_gnt1);
      end
      checks++;
      if (perf_conflict !== 32'd4) begin
         errors++;
         $display("FAIL perf_conflict: got %0d want 4", perf_conflict);
      end
`endif
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      bus.m_rdata = 32'd0;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_funct3 = 3'd0;
      bus.p0_addr = 32'd0; bus.p0_wdata = 32'd0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_funct3 = 3'd0;
      bus.p1_addr = 32'd0; bus.p1_wdata = 32'd0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_store_load();
      test_sign_ext();
      test_reject();
      test_reset_mid();
      test_round_robin();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
